// File: rtl/intr_control_if.sv
// Bus bundle between the interrupt scheduler and the core blocks around it.
// slave  : the intr_control side (request and control inputs, status outputs)
// master : the driver side (control_pins / execute / sequencer)
// Signals:
//   nmi, intr           request inputs from control_pins
//   instr_end           last T-state pulse of each instruction
//   ctl_ei/di/retn      IFF control strobes from execute
//   ctl_im_we, im_sel   interrupt mode load
//   iff1, iff2, im      interrupt enable state
//   nmi_pending         latched NMI edge not yet serviced
//   take_nmi, take_int  acceptance pulses
//   ack_active          acknowledge window in progress
//   ack_is_nmi          current/last acknowledge was an NMI
//   vector              restart low byte
//   vec_from_bus        vector/opcode comes from the data bus
interface intr_control_if;
    logic       nmi;
    logic       intr;
    logic       instr_end;
    logic       ctl_ei;
    logic       ctl_di;
    logic       ctl_retn;
    logic       ctl_im_we;
    logic [1:0] im_sel;
    logic       iff1;
    logic       iff2;
    logic [1:0] im;
    logic       nmi_pending;
    logic       take_nmi;
    logic       take_int;
    logic       ack_active;
    logic       ack_is_nmi;
    logic [7:0] vector;
    logic       vec_from_bus;

    modport slave (
        input  nmi, intr, instr_end, ctl_ei, ctl_di, ctl_retn, ctl_im_we, im_sel,
        output iff1, iff2, im, nmi_pending, take_nmi, take_int, ack_active, ack_is_nmi,
               vector, vec_from_bus
    );

    modport master (
        output nmi, intr, instr_end, ctl_ei, ctl_di, ctl_retn, ctl_im_we, im_sel,
        input  iff1, iff2, im, nmi_pending, take_nmi, take_int, ack_active, ack_is_nmi,
               vector, vec_from_bus
    );
endinterface

// File: rtl/intr_control.sv
// Z80 interrupt scheduler. Synchronizes NMI/INT, holds IFF1/IFF2 and the
// interrupt mode, and at instruction boundaries decides whether to divert
// into an interrupt acknowledge of ACK_CYCLES clocks.
// Ports:
//   clk    core clock
//   reset  synchronous active-high reset
//   bus    intr_control_if.slave (requests, control strobes, status/vector)
module intr_control #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_CYCLES  = 4
) (
    input  logic          clk,
    input  logic          reset,
    intr_control_if.slave bus
);

    localparam int unsigned CntW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

    typedef enum logic [0:0] {StIdle, StAck} state_e;

    state_e                 state_q;
    logic [CntW-1:0]        ack_cnt_q;
    logic [SYNC_STAGES-1:0] nmi_sync_q;
    logic [SYNC_STAGES-1:0] intr_sync_q;
    logic                   nmi_prev_q;
    logic                   ei_block_q;
    logic                   iff1_q;
    logic                   iff2_q;
    logic [1:0]             im_q;
    logic                   nmi_pending_q;
    logic                   ack_active_q;
    logic                   ack_is_nmi_q;
    logic [7:0]             vector_q;
    logic                   vec_from_bus_q;

    logic nmi_s;
    logic intr_s;
    logic nmi_edge;
    logic boundary;
    logic take_nmi;
    logic take_int;

    assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
    assign intr_s   = intr_sync_q[SYNC_STAGES-1];
    assign nmi_edge = nmi_s & ~nmi_prev_q;

    // Decisions are made combinationally in the instr_end cycle so that the
    // same-cycle ctl_ei / ctl_di strobes can veto an INT.
    always_comb begin
        boundary = (state_q == StIdle) && bus.instr_end;
        take_nmi = boundary && nmi_pending_q;
        take_int = boundary && !nmi_pending_q && intr_s && iff1_q && !ei_block_q &&
                   !bus.ctl_ei && !bus.ctl_di;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            ack_cnt_q      <= '0;
            nmi_sync_q     <= '0;
            intr_sync_q    <= '0;
            nmi_prev_q     <= 1'b0;
            ei_block_q     <= 1'b0;
            iff1_q         <= 1'b0;
            iff2_q         <= 1'b0;
            im_q           <= 2'd0;
            nmi_pending_q  <= 1'b0;
            ack_active_q   <= 1'b0;
            ack_is_nmi_q   <= 1'b0;
            vector_q       <= 8'h00;
            vec_from_bus_q <= 1'b0;
        end else begin
            nmi_sync_q[0]  <= bus.nmi;
            intr_sync_q[0] <= bus.intr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                nmi_sync_q[i]  <= nmi_sync_q[i-1];
                intr_sync_q[i] <= intr_sync_q[i-1];
            end
            nmi_prev_q <= nmi_s;

            // A fresh edge wins over the clear from take_nmi.
            if (nmi_edge) begin
                nmi_pending_q <= 1'b1;
            end else if (take_nmi) begin
                nmi_pending_q <= 1'b0;
            end

            if (take_nmi) begin
                iff1_q <= 1'b0;
            end else if (take_int || bus.ctl_di) begin
                iff1_q <= 1'b0;
                iff2_q <= 1'b0;
            end else if (bus.ctl_ei) begin
                iff1_q <= 1'b1;
                iff2_q <= 1'b1;
            end else if (bus.ctl_retn) begin
                iff1_q <= iff2_q;
            end

            // EI shadow: survives EI's own instr_end only if EI is still asserted.
            if (bus.ctl_ei) begin
                ei_block_q <= 1'b1;
            end else if (bus.instr_end) begin
                ei_block_q <= 1'b0;
            end

            if (bus.ctl_im_we && (bus.im_sel != 2'd3)) begin
                im_q <= bus.im_sel;
            end

            if (take_nmi) begin
                ack_is_nmi_q   <= 1'b1;
                vector_q       <= 8'h66;
                vec_from_bus_q <= 1'b0;
            end else if (take_int) begin
                ack_is_nmi_q   <= 1'b0;
                vector_q       <= (im_q == 2'd1) ? 8'h38 : 8'h00;
                vec_from_bus_q <= (im_q != 2'd1);
            end

            case (state_q)
                StIdle: begin
                    if (take_nmi || take_int) begin
                        state_q      <= StAck;
                        ack_cnt_q    <= CntW'(ACK_CYCLES - 1);
                        ack_active_q <= 1'b1;
                    end
                end
                StAck: begin
                    if (ack_cnt_q == '0) begin
                        state_q      <= StIdle;
                        ack_active_q <= 1'b0;
                    end else begin
                        ack_cnt_q <= ack_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    ack_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.iff1         = iff1_q;
    assign bus.iff2         = iff2_q;
    assign bus.im           = im_q;
    assign bus.nmi_pending  = nmi_pending_q;
    assign bus.take_nmi     = take_nmi;
    assign bus.take_int     = take_int;
    assign bus.ack_active   = ack_active_q;
    assign bus.ack_is_nmi   = ack_is_nmi_q;
    assign bus.vector       = vector_q;
    assign bus.vec_from_bus = vec_from_bus_q;

endmodule

// File: tb/tb_intr_control.sv
// Directed bench for intr_control with hand-computed expectations.
module tb_intr_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    intr_control_if bus ();

    intr_control #(
        .SYNC_STAGES(2),
        .ACK_CYCLES (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.nmi = 0; bus.intr = 0; bus.instr_end = 0;
        bus.ctl_ei = 0; bus.ctl_di = 0; bus.ctl_retn = 0;
        bus.ctl_im_we = 0; bus.im_sel = 2'd0;

        // Reset state
        ticks(3);
        chk("rst_iff1", bus.iff1, 0);
        chk("rst_iff2", bus.iff2, 0);
        chk("rst_im", bus.im, 0);
        chk("rst_pend", bus.nmi_pending, 0);
        chk("rst_ack", bus.ack_active, 0);
        chk("rst_isnmi", bus.ack_is_nmi, 0);
        chk("rst_vec", bus.vector, 8'h00);
        chk("rst_vfb", bus.vec_from_bus, 0);
        reset = 0;
        tick();

        // 1: IM1 + EI, INT blocked by EI shadow, taken at next boundary
        bus.ctl_ei = 1; bus.ctl_im_we = 1; bus.im_sel = 2'd1; bus.intr = 1;
        tick();
        bus.ctl_ei = 0; bus.ctl_im_we = 0;
        chk("t1_iff1", bus.iff1, 1);
        chk("t1_iff2", bus.iff2, 1);
        chk("t1_im", bus.im, 1);
        ticks(4);
        bus.instr_end = 1; #1;
        chk("t1_notake", bus.take_int, 0);
        tick(); bus.instr_end = 0;
        ticks(4);
        bus.instr_end = 1; #1;
        chk("t1_take", bus.take_int, 1);
        chk("t1_nonmi", bus.take_nmi, 0);
        tick(); bus.instr_end = 0;
        chk("t1_vec", bus.vector, 8'h38);
        chk("t1_vfb", bus.vec_from_bus, 0);
        chk("t1_iff1c", bus.iff1, 0);
        chk("t1_iff2c", bus.iff2, 0);
        chk("t1_isnmi", bus.ack_is_nmi, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_ackhi", bus.ack_active, 1);
            tick();
        end
        chk("t1_acklo", bus.ack_active, 0);
        bus.instr_end = 1; #1;
        chk("t1_iff0", bus.take_int, 0);
        tick(); bus.instr_end = 0;

        // 2: single-cycle NMI, 3-cycle latency to nmi_pending, RETN restores IFF1
        bus.intr = 0; bus.ctl_ei = 1;
        tick(); bus.ctl_ei = 0;
        bus.nmi = 1;
        tick(); bus.nmi = 0;
        chk("t2_pend1", bus.nmi_pending, 0);
        tick();
        chk("t2_pend2", bus.nmi_pending, 0);
        tick();
        chk("t2_pend3", bus.nmi_pending, 1);
        bus.instr_end = 1; #1;
        chk("t2_take", bus.take_nmi, 1);
        chk("t2_noint", bus.take_int, 0);
        tick(); bus.instr_end = 0;
        chk("t2_pendc", bus.nmi_pending, 0);
        chk("t2_iff1", bus.iff1, 0);
        chk("t2_iff2", bus.iff2, 1);
        chk("t2_vec", bus.vector, 8'h66);
        chk("t2_vfb", bus.vec_from_bus, 0);
        chk("t2_isnmi", bus.ack_is_nmi, 1);
        chk("t2_ack", bus.ack_active, 1);
        bus.ctl_retn = 1;
        tick(); bus.ctl_retn = 0;
        chk("t2_retn", bus.iff1, 1);
        ticks(4);
        chk("t2_acklo", bus.ack_active, 0);

        // 3: NMI and INT at the same boundary -> NMI only; then INT needs IFF1
        bus.intr = 1; bus.nmi = 1;
        tick(); bus.nmi = 0;
        ticks(2);
        bus.instr_end = 1; #1;
        chk("t3_nmi", bus.take_nmi, 1);
        chk("t3_noint", bus.take_int, 0);
        tick(); bus.instr_end = 0;
        chk("t3_iff1", bus.iff1, 0);
        ticks(5);
        bus.instr_end = 1; #1;
        chk("t3_blocked", bus.take_int, 0);
        tick(); bus.instr_end = 0;
        bus.ctl_retn = 1;
        tick(); bus.ctl_retn = 0;
        chk("t3_retn", bus.iff1, 1);
        bus.instr_end = 1; #1;
        chk("t3_int", bus.take_int, 1);
        tick(); bus.instr_end = 0;
        chk("t3_vec", bus.vector, 8'h38);
        chk("t3_isnmi", bus.ack_is_nmi, 0);
        ticks(5);

        // 4: DI in the boundary cycle vetoes INT
        bus.ctl_ei = 1;
        tick(); bus.ctl_ei = 0;
        bus.instr_end = 1; #1;
        chk("t4_shadow", bus.take_int, 0);
        tick();
        bus.ctl_di = 1; #1;
        chk("t4_di", bus.take_int, 0);
        tick(); bus.instr_end = 0; bus.ctl_di = 0;
        chk("t4_iff1", bus.iff1, 0);
        chk("t4_iff2", bus.iff2, 0);
        chk("t4_ack", bus.ack_active, 0);

        // 5: IM2, im_sel=3 ignored, INT vector from bus
        bus.ctl_im_we = 1; bus.im_sel = 2'd2;
        tick();
        chk("t5_im2", bus.im, 2);
        bus.im_sel = 2'd3;
        tick(); bus.ctl_im_we = 0;
        chk("t5_im3", bus.im, 2);
        bus.ctl_ei = 1;
        tick(); bus.ctl_ei = 0;
        bus.instr_end = 1;
        tick();
        bus.nmi = 1; #1;
        chk("t5_take", bus.take_int, 1);
        tick(); bus.instr_end = 0; bus.nmi = 0;
        chk("t5_vec", bus.vector, 8'h00);
        chk("t5_vfb", bus.vec_from_bus, 1);
        chk("t5_ack1", bus.ack_active, 1);

        // 6: reset in the 2nd ACK cycle aborts at once
        tick();
        chk("t6_ack2", bus.ack_active, 1);
        reset = 1;
        tick();
        chk("t6_ack", bus.ack_active, 0);
        chk("t6_iff1", bus.iff1, 0);
        chk("t6_iff2", bus.iff2, 0);
        chk("t6_im", bus.im, 0);
        chk("t6_pend", bus.nmi_pending, 0);
        chk("t6_vfb", bus.vec_from_bus, 0);
        reset = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_control.md
Name: intr_control

Overview:
- Interrupt scheduler for the Z80 core. Synchronizes the NMI and INT requests, holds the interrupt flip-flops IFF1/IFF2 and the interrupt mode, and decides at instruction boundaries whether to divert into an interrupt response.
- Drives a timed acknowledge window that the sequencer and pin control use to run the interrupt-acknowledge M1 cycle.
- Supplies the restart vector, or flags that the vector comes from the data bus.
- Sits between control_pins (nmi/intr inputs) and the execute/sequencer blocks.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the nmi and intr input synchronizers (minimum 1)
ACK_CYCLES, 4, clock cycles ack_active stays high per acknowledge (minimum 1)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
nmi  in  1  NMI request, active high (pad already inverted)
intr  in  1  maskable INT request, active-high level
instr_end  in  1  one-cycle pulse on the last T-state of every instruction, including HALT NOP cycles
ctl_ei  in  1  EI executing: set IFF1 and IFF2
ctl_di  in  1  DI executing: clear IFF1 and IFF2
ctl_retn  in  1  RETN executing: IFF1 <= IFF2
ctl_im_we  in  1  load interrupt mode
im_sel  in  2  mode to load (0, 1 or 2)
iff1  out  1  interrupt enable flip-flop 1
iff2  out  1  interrupt enable flip-flop 2
im  out  2  current interrupt mode
nmi_pending  out  1  latched NMI edge not yet serviced
take_nmi  out  1  one-cycle pulse: NMI accepted
take_int  out  1  one-cycle pulse: INT accepted
ack_active  out  1  acknowledge window in progress
ack_is_nmi  out  1  current or last acknowledge is an NMI
vector  out  8  restart low byte: 8'h66 (NMI), 8'h38 (IM1), 8'h00 otherwise
vec_from_bus  out  1  IM0/IM2 INT ack: vector or opcode is read from the data bus

Behaviour:
- Reset: all outputs, synchronizer flops, the EI block counter and the ack counter are cleared to 0. State goes to IDLE. Reset during ACK aborts immediately.
- Synchronizers:
  - nmi_s and intr_s are nmi and intr delayed by SYNC_STAGES flops.
  - A rising edge of nmi_s (previous 0, current 1) sets nmi_pending. nmi_pending stays set until take_nmi.
  - An NMI edge seen in the same cycle as take_nmi re-sets nmi_pending; a new edge wins over the clear.
  - Edges are latched in every state, including ACK.
- IFF updates (registered, one cycle latency), priority highest first:
  1. take_nmi: IFF1 <= 0, IFF2 unchanged.
  2. take_int: IFF1 <= 0, IFF2 <= 0.
  3. ctl_di: both <= 0.
  4. ctl_ei: both <= 1.
  5. ctl_retn: IFF1 <= IFF2.
- EI shadow:
  - ctl_ei loads ei_block <= 1.
  - Each instr_end with ei_block = 1 and no ctl_ei in that cycle clears ei_block.
  - INT is blocked while ei_block = 1 or ctl_ei = 1. Result: no INT after EI's own instr_end; INT is possible after the next instruction.
  - NMI is unaffected by ei_block.
- IM: ctl_im_we with im_sel in {0, 1, 2} loads im next cycle. im_sel = 3 is ignored and im holds.
- FSM states: IDLE, ACK.
  - In IDLE on instr_end, if nmi_pending: pulse take_nmi, clear nmi_pending, ack_is_nmi <= 1, go to ACK.
  - Else if intr_s && iff1 && !ei_block && !ctl_ei && !ctl_di: pulse take_int, ack_is_nmi <= 0, go to ACK.
  - Otherwise stay in IDLE.
  - NMI has priority when both are eligible. A pending INT is not remembered; intr is level-sensitive and re-sampled at the next instr_end.
  - ACK: ack_active = 1 for exactly ACK_CYCLES cycles, starting the cycle after the take pulse. Counter runs ACK_CYCLES-1 down to 0; at 0 return to IDLE.
  - instr_end and ctl_* during ACK: instr_end is ignored. ctl_* still update IFF/IM.
- vector and vec_from_bus are registered with the take pulse and hold until the next take:
  - NMI: vector = 8'h66, vec_from_bus = 0.
  - INT, im = 1: vector = 8'h38, vec_from_bus = 0.
  - INT, im = 0 or 2: vector = 8'h00, vec_from_bus = 1.
- An NMI arriving during an INT ACK is serviced at the first instr_end after ACK ends.

Test Plan:
- Reset, then drive im_sel = 1 with ctl_im_we, ctl_ei, intr = 1, and three instr_end pulses 5 cycles apart -> no take at the 1st instr_end. take_int at the 2nd. vector = 8'h38, vec_from_bus = 0, iff1 = iff2 = 0, ack_active high for 4 cycles.
- Single nmi pulse of 1 cycle with iff1 = iff2 = 1, then instr_end -> nmi_pending rises 3 cycles after nmi (2 sync stages plus the edge-detect register). take_nmi follows, iff1 = 0, iff2 = 1, vector = 8'h66. ctl_retn afterwards restores iff1 = 1.
- nmi edge and intr = 1 eligible at the same instr_end -> take_nmi only. After ACK, the next instr_end gives take_int only if iff1 is still 1; with iff1 = 0 (NMI cleared it) no take.
- DI with intr = 1 and ctl_di in the same cycle as instr_end -> no take_int, iff1 = iff2 = 0.
- im_sel = 3 with ctl_im_we after IM2 -> im stays 2. A later INT gives vector = 8'h00, vec_from_bus = 1.
- reset asserted in the 2nd cycle of ACK -> next cycle ack_active = 0, iff1 = iff2 = 0, im = 0, nmi_pending = 0.
